// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding,
// the IF/ID bundle layout consumed by decode, and address helpers.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

    // {pc4[63:32], instr[31:0]}
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_id_t;

    function automatic logic [31:0] word_align(
        input logic [31:0] addr
    );
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, load and hold controls.
// When none is asserted a bubble (NOP, valid=0) enters decode.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output logic   valid,
    output if_id_t q
);

    logic   valid_d;
    logic   valid_q;
    if_id_t q_d;
    if_id_t q_q;

    // flush beats load, load beats hold; pc4 survives a bubble
    always_comb begin
        valid_d = valid_q;
        q_d     = q_q;
        if (flush) begin
            valid_d  = 1'b0;
            q_d.instr = NOP_INSTR;
        end else if (load) begin
            valid_d = 1'b1;
            q_d     = d;
        end else if (!hold) begin
            valid_d  = 1'b0;
            q_d.instr = NOP_INSTR;
        end
    end

    // register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            q_q     <= '0;
        end else begin
            valid_q <= valid_d;
            q_q     <= q_d;
        end
    end

    assign valid = valid_q;
    assign q     = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem req/ack port, skid buffer, IF/ID load.
// Macro FETCH_PERF_CNT_EN builds the fetched/stall perf counters.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    fetch_state_t state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  redir_d, redir_q;
    if_id_t       skid_d, skid_q;
    logic         req_q;

    logic         load;
    if_id_t       if_id_d;
    if_id_t       if_id_q;
    if_id_t       fetched;
    logic [31:0]  pc4;
    logic [31:0]  tgt;

    // next-state: a branch always wins over ack and stall
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        skid_d  = skid_q;
        load    = 1'b0;
        if_id_d = skid_q;
        pc4     = pc_q + PC_INC;
        tgt     = word_align(branch_target);
        fetched.pc4   = pc4;
        fetched.instr = imem_rdata;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (branch_taken) pc_d = tgt;
            end
            FETCH: begin
                if (branch_taken) begin
                    if (imem_ack) begin
                        pc_d = tgt;
                    end else begin
                        redir_d = tgt;
                        state_d = SQUASH;
                    end
                end else if (imem_ack) begin
                    pc_d = pc4;
                    if (stall) begin
                        skid_d  = fetched;
                        state_d = HOLD;
                    end else begin
                        load    = 1'b1;
                        if_id_d = fetched;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d    = tgt;
                    state_d = FETCH;
                end else if (!stall) begin
                    load    = 1'b1;
                    state_d = FETCH;
                end
            end
            SQUASH: begin
                if (branch_taken) begin
                    if (imem_ack) begin
                        pc_d    = tgt;
                        state_d = FETCH;
                    end else begin
                        redir_d = tgt;
                    end
                end else if (imem_ack) begin
                    pc_d    = redir_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, PC and skid flops; request is registered off next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            redir_q <= RESET_PC;
            skid_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            skid_q  <= skid_d;
            req_q   <= (state_d == FETCH) ||
                       (state_d == SQUASH);
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .flush (branch_taken),
        .hold  (stall),
        .d     (if_id_d),
        .valid (if_id_valid),
        .q     (if_id_q)
    );

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fet_cnt_d, fet_cnt_q;
    logic [31:0] stl_cnt_d, stl_cnt_q;

    // count IF/ID loads and stalled cycles, wrapping
    always_comb begin
        fet_cnt_d = fet_cnt_q + {31'd0, load};
        stl_cnt_d = stl_cnt_q + {31'd0, stall};
    end

    // counter flops, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fet_cnt_q <= '0;
            stl_cnt_q <= '0;
        end else begin
            fet_cnt_q <= fet_cnt_d;
            stl_cnt_q <= stl_cnt_d;
        end
    end

    assign perf_fetched = fet_cnt_q;
    assign perf_stall   = stl_cnt_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a
// randomized run against a transaction-level fetch model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;

    int checks = 0;
    int errors = 0;

    // memory: fixed wait states, or random 0..3 when negative
    int wait_cfg = 0;
    int wcnt = 0;

    // reference model: architectural fetch stream
    bit          m_started;
    bit          m_kill;
    logic [31:0] m_pc;
    logic [31:0] m_redir;
    logic [63:0] m_skid[$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000;
    endfunction

    function automatic int pick_wait();
        if (wait_cfg < 0) return $urandom_range(0, 3);
        return wait_cfg;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        stall = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        repeat (2) @(negedge clk);
        m_started = 0;
        m_kill = 0;
        m_pc = '0;
        m_redir = '0;
        m_skid.delete();
        m_valid = 0;
        m_instr = '0;
        m_pc4 = '0;
        m_fetched = '0;
        m_stall = '0;
        wcnt = pick_wait();
        rst_n = 1'b1;
    endtask

    // drive one cycle from a negedge, advance model, land on next negedge
    task automatic drive(input logic br, input logic [31:0] tgt,
                         input logic st);
        logic        ack;
        logic        mreq;
        logic [31:0] t;
        logic [63:0] item;
        ack = 1'b0;
        if (imem_req) begin
            if (wcnt == 0) begin
                ack = 1'b1;
                wcnt = pick_wait();
            end else begin
                wcnt--;
            end
        end
        imem_ack = ack;
        imem_rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        branch_taken = br;
        branch_target = tgt;
        stall = st;
        mreq = m_started && (m_skid.size() == 0);
        t = {tgt[31:2], 2'b00};
        if (st) m_stall++;
        if (br) begin
            m_valid = 0;
            m_instr = '0;
            m_skid.delete();
            if (m_started && mreq && !ack) begin
                m_kill = 1;
                m_redir = t;
            end else begin
                m_kill = 0;
                m_pc = t;
            end
            m_started = 1;
        end else if (!m_started) begin
            m_started = 1;
            if (!st) begin m_valid = 0; m_instr = '0; end
        end else if (m_skid.size() != 0) begin
            if (!st) begin
                item = m_skid.pop_front();
                {m_pc4, m_instr} = item;
                m_valid = 1;
                m_fetched++;
            end
        end else if (mreq && ack) begin
            if (m_kill) begin
                m_kill = 0;
                m_pc = m_redir;
                if (!st) begin m_valid = 0; m_instr = '0; end
            end else begin
                item = {m_pc + 32'd4, mem_word(m_pc)};
                m_pc = m_pc + 32'd4;
                if (st) begin
                    m_skid.push_back(item);
                end else begin
                    {m_pc4, m_instr} = item;
                    m_valid = 1;
                    m_fetched++;
                end
            end
        end else if (!st) begin
            m_valid = 0;
            m_instr = '0;
        end
        @(negedge clk);
        branch_taken = 1'b0;
        stall = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        wait_cfg = 2;
        do_reset();
        checks++; if (imem_req !== 1'b0) begin errors++;
            $display("FAIL rst_req got %0b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++;
            $display("FAIL rst_addr got %h want 0", imem_addr); end
        checks++; if (if_id_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got %0b want 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'h0) begin errors++;
            $display("FAIL rst_instr got %h want 0", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'h0) begin errors++;
            $display("FAIL rst_pc4 got %h want 0", if_id_pc4); end
        checks++; if (perf_fetched !== 0 || perf_stall !== 0) begin
            errors++; $display("FAIL rst_perf got %h/%h want 0/0",
                               perf_fetched, perf_stall); end
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req got %0b@%h want 1@0",
                               imem_req, imem_addr); end
        drive(1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst got req=%0b v=%0b want 0/0",
                               imem_req, if_id_valid); end
    endtask

    task automatic test_zero_wait();
        wait_cfg = 0;
        do_reset();
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            checks++;
            if (if_id_valid !== 1'b1 ||
                if_id_instr !== 32'h1000 + 32'(4 * i) ||
                if_id_pc4 !== 32'(4 * (i + 1))) begin
                errors++;
                $display("FAIL zero_wait[%0d] got v=%0b %h/%h want %h/%h",
                         i, if_id_valid, if_id_instr, if_id_pc4,
                         32'h1000 + 32'(4 * i), 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall_skid();
        wait_cfg = 0;
        do_reset();
        repeat (5) drive(1'b0, 32'h0, 1'b0);
        checks++; if (imem_addr !== 32'h10) begin errors++;
            $display("FAIL skid_pre got %h want 10", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            checks++;
            if (imem_req !== 1'b0 || if_id_instr !== 32'h100C) begin
                errors++;
                $display("FAIL skid_hold[%0d] got req=%0b %h want 0/100c",
                         i, imem_req, if_id_instr);
            end
        end
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== 32'h1010 ||
            if_id_pc4 !== 32'h14) begin
            errors++; $display("FAIL skid_release got %0b %h/%h want 1 1010/14",
                               if_id_valid, if_id_instr, if_id_pc4);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            errors++; $display("FAIL skid_next_req got %0b@%h want 1@14",
                               imem_req, imem_addr); end
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (if_id_instr !== 32'h1014) begin errors++;
            $display("FAIL skid_after got %h want 1014", if_id_instr); end
    endtask

    task automatic test_branch_wait();
        bit got;
        wait_cfg = 2;
        do_reset();
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h80, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
                errors++; $display("FAIL br_wait_sq[%0d] got %h v=%0b want 0/0",
                                   i, imem_addr, if_id_valid);
            end
            drive(1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL br_wait_tgt got %h v=%0b want 80/0",
                               imem_addr, if_id_valid);
        end
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            got = if_id_valid;
        end
        checks++;
        if (!got || if_id_instr !== 32'h1080 || if_id_pc4 !== 32'h84) begin
            errors++; $display("FAIL br_wait_load got v=%0b %h/%h want 1 1080/84",
                               got, if_id_instr, if_id_pc4);
        end
    endtask

    task automatic test_hold_branch();
        wait_cfg = 0;
        do_reset();
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h200, 1'b1);
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
            imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL hold_br got v=%0b %h req=%0b@%h want 0 0 1@200",
                               if_id_valid, if_id_instr, imem_req, imem_addr);
        end
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (if_id_instr !== 32'h1200 || if_id_pc4 !== 32'h204) begin
            errors++; $display("FAIL hold_br_next got %h/%h want 1200/204",
                               if_id_instr, if_id_pc4);
        end
    endtask

    task automatic test_squash_double();
        bit got;
        wait_cfg = 2;
        do_reset();
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h40, 1'b0);
        drive(1'b1, 32'h60, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (imem_addr !== 32'h60) begin errors++;
            $display("FAIL sq2_addr got %h want 60", imem_addr); end
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            got = if_id_valid;
        end
        checks++;
        if (!got || if_id_instr !== 32'h1060 || if_id_pc4 !== 32'h64) begin
            errors++; $display("FAIL sq2_load got v=%0b %h/%h want 1 1060/64",
                               got, if_id_instr, if_id_pc4);
        end
        wait_cfg = 0;
        wcnt = 0;
        drive(1'b1, 32'hFFFF_FFFF, 1'b0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h0 ||
            if_id_instr !== 32'h0000_0FFC || imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_load got v=%0b %h/%h a=%h want 1 ffc/0 a=0",
                               if_id_valid, if_id_instr, if_id_pc4, imem_addr);
        end
    endtask

    task automatic test_perf();
        logic [31:0] ef, es;
`ifdef FETCH_PERF_CNT_EN
        ef = 32'd10;
        es = 32'd3;
`else
        ef = 32'd0;
        es = 32'd0;
`endif
        wait_cfg = 0;
        do_reset();
        drive(1'b0, 32'h0, 1'b0);
        repeat (9) drive(1'b0, 32'h0, 1'b0);
        repeat (3) drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (perf_fetched !== ef || perf_stall !== es) begin
            errors++; $display("FAIL perf got %0d/%0d want %0d/%0d",
                               perf_fetched, perf_stall, ef, es);
        end
    endtask

    task automatic test_random();
        logic        br, st, ereq;
        logic [31:0] tgt, ef, es;
        int          bad;
        wait_cfg = -1;
        do_reset();
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            br = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                tgt = 32'($urandom_range(0, 1023));
            drive(br, tgt, st);
            ereq = m_started && (m_skid.size() == 0);
`ifdef FETCH_PERF_CNT_EN
            ef = m_fetched;
            es = m_stall;
`else
            ef = 32'h0;
            es = 32'h0;
`endif
            checks++;
            if (imem_req !== ereq ||
                (ereq && imem_addr !== m_pc) ||
                if_id_valid !== m_valid ||
                if_id_instr !== m_instr ||
                if_id_pc4 !== m_pc4 ||
                perf_fetched !== ef || perf_stall !== es) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand[%0d] got req=%0b a=%h v=%0b %h/%h p=%0d/%0d want req=%0b a=%h v=%0b %h/%h p=%0d/%0d",
                             n, imem_req, imem_addr, if_id_valid,
                             if_id_instr, if_id_pc4, perf_fetched,
                             perf_stall, ereq, m_pc, m_valid, m_instr,
                             m_pc4, ef, es);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_branch_wait();
        test_hold_branch();
        test_squash_double();
        test_perf();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the five-stage MIPS pipeline, sitting directly upstream of the decode stage. It owns the PC, drives a request/acknowledge instruction-memory port, and loads the IF/ID pipeline register. It handles load-use stalls from the hazard unit and branch redirects resolved in the memory stage, including redirects that arrive while a fetch is still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- branch_taken  in  1  PCSrc from the memory stage; single-cycle redirect pulse.
- branch_target  in  32  redirect address, valid when branch_taken=1.
- stall  in  1  hazard-unit stall; IF/ID must hold its contents.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  word address; stable while imem_req=1 and no ack.
- imem_ack  in  1  read data valid this cycle; may come in the same cycle as req.
- imem_rdata  in  32  instruction word.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_instr  out  32  IF/ID instruction; 32'h0 (NOP) when invalid.
- if_id_pc4  out  32  IF/ID incremented PC (fetch address + 4).
- perf_fetched  out  32  instructions loaded into IF/ID (see Configuration).
- perf_stall  out  32  cycles with stall=1 (see Configuration).

## Operation
- All arithmetic is 32-bit modulo: pc + 4 wraps 32'hFFFF_FFFC to 0. Bits [1:0] of branch_target are ignored and forced to 0.
- Registers: pc (current fetch address), redir_pc, skid buffer (instr, pc4), and state.
- IDLE: this is the reset state; imem_req=0. The next state is always FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - ack with stall=0: IF/ID <= {rdata, pc+4}, valid=1; pc <= pc+4; stay in FETCH.
  - ack with stall=1: skid <= {rdata, pc+4}; pc <= pc+4; go to HOLD.
  - no ack: hold pc.
- HOLD: imem_req=0; IF/ID is frozen. When stall=0, IF/ID <= skid, valid=1, then go to FETCH.
- SQUASH: imem_req=1 at the old pc, because the address cannot change mid-request. On ack, rdata is discarded, pc <= redir_pc, then go to FETCH.
- Branch priority: branch_taken overrides stall and ack in every state, and it always clears IF/ID (valid=0, instr=0, pc4 held).
  - FETCH with ack in the same cycle: data is discarded; pc <= target; stay in FETCH.
  - FETCH without ack: redir_pc <= target; go to SQUASH.
  - SQUASH: redir_pc <= newest target; stay in SQUASH, unless ack arrives the same cycle, in which case pc <= target and go to FETCH.
  - HOLD: the skid buffer is discarded; pc <= target; go to FETCH.
  - IDLE: pc <= target.
- With stall=1 and no branch, IF/ID is never written.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc4=0, perf counters=0.
- First request is in the first cycle after rst_n deasserts.
- Reset mid-request drops the transaction. The memory model must tolerate a request withdrawn without ack.
- Latency from ack to IF/ID is 1 edge (captured on the ack edge, visible the next cycle).
- With zero-wait memory (ack comes with req), throughput is 1 instruction per cycle.
- Stall release from HOLD: IF/ID is updated on the edge where stall is sampled 0, and the new request is issued the following cycle.
- Branch penalty with zero-wait memory: the target request is issued the cycle after the branch_taken edge.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - perf_fetched increments on each IF/ID load with valid=1.
  - perf_stall increments each cycle stall=1.
  - Both are 32-bit, wrap at 2^32, and are cleared only by rst_n.
- Undefined: both ports are tied to 32'h0 and no counter flops are built.

## Structure
- mips_pkg holds:
  - NOP_INSTR = 32'h0.
  - PC_INC = 32'd4.
  - the fetch_state_t encoding (IDLE, FETCH, HOLD, SQUASH).
  - the IF/ID field layout {pc4[63:32], instr[31:0]}, shared with decode.
- Sub-module if_id_reg: the 64-bit+valid register with load, flush and hold inputs. Flush takes priority over load, and load takes priority over hold.

## Test plan
- Reset, then zero-wait memory returning addr+32'h1000: if_id_instr = 32'h1000, 32'h1004, 32'h1008 on consecutive cycles; if_id_pc4 = 4, 8, 12.
- Stall held for 3 cycles during an acked fetch of 0x10: the skid buffer is used, imem_req=0 for 3 cycles, and IF/ID loads instr@0x10 with pc4=0x14 on release; no instruction is lost or duplicated.
- Memory with 2 wait states, branch_taken with target 0x80 in the first wait cycle: the old ack is discarded, imem_addr=0x80 next, and IF/ID is invalid until instr@0x80.
- Branch and stall in the same cycle while in HOLD: the skid buffer is dropped, IF/ID is flushed (instr=0), and the next fetch is at the target.
- Two branches during SQUASH (targets 0x40, then 0x60): the fetch resumes at 0x60; pc wrap from 0xFFFF_FFFC gives if_id_pc4=0.
- With FETCH_PERF_CNT_EN: 10 fetches and 3 stall cycles give perf_fetched=10 and perf_stall=3. Without the macro, both read 0.
